// File: rtl/pixel_burst_writer_pkg.sv
// Shared constants and FSM encoding for the pixel burst writer.
// Frame geometry, bank layout and burst size live here so both sides of the frame buffer agree.
package pixel_burst_writer_pkg;

    localparam int PBW_H_AP        = 1280;
    localparam int PBW_V_AP        = 720;
    localparam int PBW_FRAME_WORDS = PBW_H_AP * PBW_V_AP;
    localparam int PBW_BURST_LEN   = 256;

    localparam logic [23:0] PBW_BANK0_BASE = 24'h000000;
    localparam logic [23:0] PBW_BANK1_BASE = 24'h100000;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FILL  = 3'd1,
        REQ   = 3'd2,
        XFER  = 3'd3,
        DRAIN = 3'd4
    } state_t;

endpackage

// File: rtl/pixel_burst_writer_sync_fifo.sv
// Single-clock FIFO with a registered read port; rd_data holds its value when no word is popped.
module pixel_burst_writer_sync_fifo #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 1024,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic [CNT_W-1:0]  count,
    output logic              full,
    output logic              empty
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              do_wr;
    logic              do_rd;

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);
    assign do_wr = wr_en & ~full;
    assign do_rd = rd_en & ~empty;

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            rd_data <= '0;
            count   <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_rd) begin
                rd_ptr  <= rd_ptr + PTR_W'(1);
                rd_data <= mem[rd_ptr];
            end
            case ({do_wr, do_rd})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/pixel_burst_writer.sv
// Buffers the camera pixel stream and writes it to SDRAM in fixed bursts,
// ping-ponging between two frame banks and publishing the last clean bank to the display side.
module pixel_burst_writer
    import pixel_burst_writer_pkg::*;
#(
    parameter int                DATA_W      = 16,
    parameter int                ADDR_W      = 24,
    parameter int                BURST_LEN   = PBW_BURST_LEN,
    parameter int                FIFO_DEPTH  = 1024,
    parameter int                FRAME_WORDS = PBW_FRAME_WORDS,
    parameter logic [ADDR_W-1:0] BANK0_BASE  = PBW_BANK0_BASE,
    parameter logic [ADDR_W-1:0] BANK1_BASE  = PBW_BANK1_BASE
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] din,
    input  logic              din_sop,
    input  logic              din_eop,
    input  logic              din_vld,
    output logic              wr_req,
    input  logic              wr_ack,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [8:0]        wr_len,
    input  logic              wr_data_req,
    output logic [DATA_W-1:0] wr_data,
    input  logic              wr_done,
    output logic              rd_bank,
    output logic              frame_done,
    output logic              frame_err,
    output logic              overflow
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    state_t            state;
    state_t            state_next;
    logic              frame_open;
    logic              frame_bad;
    logic              wr_bank;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       word_cnt;
    logic [31:0]       next_cnt;
    logic [CNT_W-1:0]  fifo_cnt;
    logic              fifo_full;
    logic              fifo_empty;
    logic              start_frame;
    logic              intrude;
    logic              take;
    logic              push;
    logic              drop;
    logic              len_bad;
    logic              open_next;
    logic              load_req;
    logic [8:0]        req_len;
    logic              finish;

    // A sop inside an open frame closes it as bad and is itself thrown away,
    // so only the eop (or a sop taken from IDLE) counts toward the frame length.
    always_comb begin
        start_frame = (state == IDLE) & din_vld & din_sop;
        intrude     = frame_open & din_vld & din_sop;
        take        = start_frame | (frame_open & din_vld & ~din_sop);
        push        = take & ~fifo_full;
        drop        = take & fifo_full;
        next_cnt    = start_frame ? 32'd1 : word_cnt + 32'd1;
        len_bad     = take & din_eop & (next_cnt != 32'(FRAME_WORDS));
        open_next   = start_frame ? ~din_eop
                                  : (frame_open & ~intrude & ~(take & din_eop));
    end

    always_comb begin
        state_next = state;
        load_req   = 1'b0;
        req_len    = 9'(BURST_LEN);
        finish     = 1'b0;
        case (state)
            IDLE: begin
                if (start_frame) begin
                    state_next = din_eop ? DRAIN : FILL;
                end
            end
            FILL: begin
                if (!open_next) begin
                    state_next = DRAIN;
                end else if (fifo_cnt >= CNT_W'(BURST_LEN)) begin
                    state_next = REQ;
                    load_req   = 1'b1;
                end
            end
            REQ: begin
                if (wr_ack) begin
                    state_next = XFER;
                end
            end
            XFER: begin
                if (wr_done) begin
                    state_next = open_next ? FILL : DRAIN;
                end
            end
            DRAIN: begin
                if (fifo_cnt >= CNT_W'(BURST_LEN)) begin
                    state_next = REQ;
                    load_req   = 1'b1;
                end else if (fifo_cnt != '0) begin
                    state_next = REQ;
                    load_req   = 1'b1;
                    req_len    = 9'(fifo_cnt);
                end else begin
                    state_next = IDLE;
                    finish     = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Dropped words still count so a frame that overflowed is also length-checked.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_open <= 1'b0;
            frame_bad  <= 1'b0;
            word_cnt   <= '0;
            overflow   <= 1'b0;
            addr       <= '0;
        end else begin
            frame_open <= open_next;
            if (take) begin
                word_cnt <= next_cnt;
            end
            if (start_frame) begin
                frame_bad <= drop | len_bad;
                addr      <= wr_bank ? BANK1_BASE : BANK0_BASE;
            end else begin
                if (intrude | drop | len_bad) begin
                    frame_bad <= 1'b1;
                end
                if ((state == XFER) && wr_done) begin
                    addr <= addr + ADDR_W'(wr_len);
                end
            end
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_req     <= 1'b0;
            wr_addr    <= '0;
            wr_len     <= '0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            rd_bank    <= 1'b1;
            wr_bank    <= 1'b0;
        end else begin
            wr_req     <= (state_next == REQ);
            frame_done <= finish;
            frame_err  <= finish & frame_bad;
            if (load_req) begin
                wr_addr <= addr;
                wr_len  <= req_len;
            end
            if (finish && !frame_bad) begin
                rd_bank <= wr_bank;
                wr_bank <= ~wr_bank;
            end
        end
    end

    pixel_burst_writer_sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (push),
        .wr_data (din),
        .rd_en   (wr_data_req & ~fifo_empty),
        .rd_data (wr_data),
        .count   (fifo_cnt),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

endmodule

// File: tb/tb_pixel_burst_writer.sv
// Bench for pixel_burst_writer with a small frame geometry and a cycle-level SDRAM write-port model.
module tb_pixel_burst_writer;

    localparam int          BL    = 8;
    localparam int          FW    = 20;
    localparam int          DEPTH = 32;
    localparam logic [23:0] B0    = 24'h000000;
    localparam logic [23:0] B1    = 24'h100000;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] din;
    logic        din_sop;
    logic        din_eop;
    logic        din_vld;
    logic        wr_req;
    logic        wr_ack;
    logic [23:0] wr_addr;
    logic [8:0]  wr_len;
    logic        wr_data_req;
    logic [15:0] wr_data;
    logic        wr_done;
    logic        rd_bank;
    logic        frame_done;
    logic        frame_err;
    logic        overflow;

    pixel_burst_writer #(
        .BURST_LEN   (BL),
        .FRAME_WORDS (FW),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .din         (din),
        .din_sop     (din_sop),
        .din_eop     (din_eop),
        .din_vld     (din_vld),
        .wr_req      (wr_req),
        .wr_ack      (wr_ack),
        .wr_addr     (wr_addr),
        .wr_len      (wr_len),
        .wr_data_req (wr_data_req),
        .wr_data     (wr_data),
        .wr_done     (wr_done),
        .rd_bank     (rd_bank),
        .frame_done  (frame_done),
        .frame_err   (frame_err),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        int pre_junk;
        int n_words;
        int intrude_at;
        int ack_delay;
        int keep;
        int l0;
        int l1;
        int l2;
        int l3;
        bit bank;
        bit exp_err;
        bit exp_rd_bank;
        bit exp_ovf;
    } vec_t;

    typedef struct packed {
        logic [23:0] addr;
        logic [8:0]  len;
    } burst_t;

    typedef struct packed {
        bit err;
        bit rd_bank;
    } frame_t;

    burst_t      exp_burst[$];
    logic [15:0] exp_pix[$];
    frame_t      exp_frame[$];
    vec_t        vecs[9];

    int vec_cnt   = 0;
    int miscnt    = 0;
    int done_cnt  = 0;
    int ack_delay = 2;
    int ctl_state = 0;

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vec_cnt++;
        if (actual !== expected) begin
            miscnt++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic report_fail(input string name, input string got, input string wanted);
        vec_cnt++;
        miscnt++;
        $display("[TB] FAIL %s: got %s, expected %s", name, got, wanted);
    endtask

    function automatic vec_t make_vec(input int pre_junk, input int n_words, input int intrude_at,
                                      input int ack_dly, input int keep, input int l0, input int l1,
                                      input int l2, input int l3, input bit bank, input bit exp_err,
                                      input bit exp_rd_bank, input bit exp_ovf);
        vec_t v;
        v.pre_junk    = pre_junk;
        v.n_words     = n_words;
        v.intrude_at  = intrude_at;
        v.ack_delay   = ack_dly;
        v.keep        = keep;
        v.l0          = l0;
        v.l1          = l1;
        v.l2          = l2;
        v.l3          = l3;
        v.bank        = bank;
        v.exp_err     = exp_err;
        v.exp_rd_bank = exp_rd_bank;
        v.exp_ovf     = exp_ovf;
        return v;
    endfunction

    // Write-port model: acks after a programmable delay, pops wr_len words, then pulses wr_done.
    initial begin : controller
        int     wait_cnt;
        int     left;
        bit     prev_req;
        burst_t b;
        frame_t f;
        wait_cnt    = 0;
        left        = 0;
        prev_req    = 1'b0;
        wr_ack      = 1'b0;
        wr_data_req = 1'b0;
        wr_done     = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                wr_ack      = 1'b0;
                wr_data_req = 1'b0;
                wr_done     = 1'b0;
                ctl_state   = 0;
                prev_req    = 1'b0;
                exp_burst.delete();
                exp_pix.delete();
                exp_frame.delete();
            end else begin
                if (prev_req) begin
                    if (exp_pix.size() == 0) report_fail("wr_data", "extra word", "no word");
                    else check_output("wr_data", 32'(wr_data), 32'(exp_pix.pop_front()));
                end
                if (frame_done) begin
                    done_cnt++;
                    if (exp_frame.size() == 0) begin
                        report_fail("frame_done", "extra pulse", "no pulse");
                    end else begin
                        f = exp_frame.pop_front();
                        check_output("frame_err", 32'(frame_err), 32'(f.err));
                        check_output("rd_bank", 32'(rd_bank), 32'(f.rd_bank));
                    end
                end
                wr_ack  = 1'b0;
                wr_done = 1'b0;
                case (ctl_state)
                    0: begin
                        if (wr_req) begin
                            wait_cnt  = ack_delay;
                            ctl_state = 1;
                        end
                    end
                    1: begin
                        if (wait_cnt > 0) begin
                            wait_cnt--;
                        end else begin
                            wr_ack = 1'b1;
                            if (exp_burst.size() == 0) begin
                                report_fail("burst", "extra request", "no request");
                            end else begin
                                b = exp_burst.pop_front();
                                check_output("wr_addr", 32'(wr_addr), 32'(b.addr));
                                check_output("wr_len", 32'(wr_len), 32'(b.len));
                            end
                            left      = int'(wr_len);
                            ctl_state = 2;
                        end
                    end
                    default: begin
                        if (left > 0) begin
                            wr_data_req = 1'b1;
                            left--;
                        end else begin
                            wr_data_req = 1'b0;
                            wr_done     = 1'b1;
                            ctl_state   = 0;
                        end
                    end
                endcase
                prev_req = wr_data_req;
            end
        end
    end

    task automatic drive_pixel(input logic [15:0] px, input logic sop, input logic eop);
        din     = px;
        din_sop = sop;
        din_eop = eop;
        din_vld = 1'b1;
        @(posedge clk);
        #2;
    endtask

    task automatic drive_idle();
        din_vld = 1'b0;
        din_sop = 1'b0;
        din_eop = 1'b0;
    endtask

    task automatic check_reset_values();
        check_output("rst wr_req", 32'(wr_req), 32'd0);
        check_output("rst wr_addr", 32'(wr_addr), 32'd0);
        check_output("rst wr_len", 32'(wr_len), 32'd0);
        check_output("rst wr_data", 32'(wr_data), 32'd0);
        check_output("rst rd_bank", 32'(rd_bank), 32'd1);
        check_output("rst frame_done", 32'(frame_done), 32'd0);
        check_output("rst frame_err", 32'(frame_err), 32'd0);
        check_output("rst overflow", 32'(overflow), 32'd0);
    endtask

    // One frame: queue the expected bursts/pixels/result, stream it, then wait for frame_done.
    task automatic apply_stimulus(input vec_t v);
        logic [23:0] base;
        logic [15:0] px;
        burst_t      b;
        frame_t      f;
        int          lens[4];
        int          target;
        base = v.bank ? B1 : B0;
        lens = '{v.l0, v.l1, v.l2, v.l3};
        for (int i = 0; i < 4; i++) begin
            if (lens[i] != 0) begin
                b.addr = base;
                b.len  = 9'(lens[i]);
                exp_burst.push_back(b);
                base   = base + 24'(lens[i]);
            end
        end
        f.err     = v.exp_err;
        f.rd_bank = v.exp_rd_bank;
        exp_frame.push_back(f);
        target    = done_cnt + 1;
        ack_delay = v.ack_delay;
        for (int i = 0; i < v.pre_junk; i++) begin
            drive_pixel(16'($urandom), 1'b0, 1'b0);
        end
        for (int i = 0; i < v.n_words; i++) begin
            px = 16'($urandom);
            if (i < v.keep) exp_pix.push_back(px);
            drive_pixel(px, (i == 0) || (i == v.intrude_at), i == v.n_words - 1);
        end
        drive_idle();
        for (int c = 0; c < 1000 && done_cnt < target; c++) @(posedge clk);
        #2;
        if (done_cnt < target) report_fail("frame_done wait", "timeout", "pulse");
        check_output("overflow", 32'(overflow), 32'(v.exp_ovf));
        repeat (2) @(posedge clk);
        #2;
    endtask

    initial begin : main
        logic [15:0] px;
        burst_t      b;
        rst = 1'b1;
        din = '0;
        drive_idle();

        vecs[0] = make_vec(3, 20, -1,  2, 20, 8, 8, 4, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        vecs[1] = make_vec(0, 20, -1,  2, 20, 8, 8, 4, 0, 1'b1, 1'b0, 1'b1, 1'b0);
        vecs[2] = make_vec(2, 15, -1,  1, 15, 8, 7, 0, 0, 1'b0, 1'b1, 1'b1, 1'b0);
        vecs[3] = make_vec(0, 20, -1,  3, 20, 8, 8, 4, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        vecs[4] = make_vec(1, 20, 10,  2, 10, 8, 2, 0, 0, 1'b1, 1'b1, 1'b0, 1'b0);
        vecs[5] = make_vec(0, 20, -1,  0, 20, 8, 8, 4, 0, 1'b1, 1'b0, 1'b1, 1'b0);
        vecs[6] = make_vec(0, 40, -1, 40, 32, 8, 8, 8, 8, 1'b0, 1'b1, 1'b1, 1'b1);
        vecs[7] = make_vec(0, 20, -1,  2, 20, 8, 8, 4, 0, 1'b0, 1'b0, 1'b0, 1'b1);
        vecs[8] = make_vec(2, 20, -1,  2, 20, 8, 8, 4, 0, 1'b0, 1'b0, 1'b0, 1'b0);

        repeat (3) @(posedge clk);
        #2;
        check_reset_values();
        rst = 1'b0;
        @(posedge clk);
        #2;

        for (int i = 0; i < 8; i++) begin
            apply_stimulus(vecs[i]);
        end

        // Open a frame in bank 1, then hit reset while its first burst is being popped.
        ack_delay = 2;
        b.addr    = B1;
        b.len     = 9'd8;
        exp_burst.push_back(b);
        for (int i = 0; i < 12; i++) begin
            px = 16'($urandom);
            if (i < 8) exp_pix.push_back(px);
            drive_pixel(px, i == 0, 1'b0);
        end
        drive_idle();
        for (int c = 0; c < 50 && ctl_state != 2; c++) begin
            @(posedge clk);
            #2;
        end
        if (ctl_state != 2) report_fail("xfer wait", "timeout", "data phase");
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_reset_values();
        @(posedge clk);
        #2;
        exp_burst.delete();
        exp_pix.delete();
        exp_frame.delete();
        rst = 1'b0;
        @(posedge clk);
        #2;
        apply_stimulus(vecs[8]);

        check_output("pending bursts", 32'(exp_burst.size()), 32'd0);
        check_output("pending pixels", 32'(exp_pix.size()), 32'd0);
        check_output("pending frames", 32'(exp_frame.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscnt);
        $finish;
    end

endmodule

// File: doc/pixel_burst_writer.md
Name: pixel_burst_writer

Overview:
- Downstream neighbour of the camera capture stage.
- Consumes the 16-bit pixel packet stream (din/din_sop/din_eop/din_vld) and buffers it in an internal synchronous FIFO.
- Issues fixed-length write bursts to the SDRAM controller's write port, generating word addresses inside one of two frame banks (ping-pong).
- After each complete, clean frame, publishes the bank the VGA read side may display.

Parameters:
- DATA_W, 16, pixel/SDRAM word width
- ADDR_W, 24, SDRAM word-address width
- BURST_LEN, 256, words per full burst (power of two, ≤ FIFO_DEPTH/2)
- FIFO_DEPTH, 1024, internal FIFO depth in words (power of two)
- FRAME_WORDS, 921600, words per frame (H_AP*V_AP = 1280*720)
- BANK0_BASE, 24'h000000, base word address of bank 0
- BANK1_BASE, 24'h100000, base word address of bank 1

Ports:
- clk  in  1  pixel/system clock
- rst  in  1  asynchronous reset, active-high
- din  in  16  pixel word
- din_sop  in  1  first pixel of frame (qualified by din_vld)
- din_eop  in  1  last pixel of frame (qualified by din_vld)
- din_vld  in  1  pixel valid
- wr_req  out  1  burst request, held until wr_ack
- wr_ack  in  1  one-cycle request accept from controller
- wr_addr  out  24  burst start word address, stable while wr_req=1
- wr_len  out  9  burst length in words (1..BURST_LEN), stable while wr_req=1
- wr_data_req  in  1  controller pops one word
- wr_data  out  16  popped word, valid the cycle after wr_data_req
- wr_done  in  1  burst completion pulse from controller
- rd_bank  out  1  bank holding the latest good frame
- frame_done  out  1  one-cycle pulse when a frame is fully written
- frame_err  out  1  qualifies frame_done: 1 = frame bad, bank not swapped
- overflow  out  1  sticky: a pixel was dropped because the FIFO was full

Behaviour:
- Reset values: wr_req=0, wr_addr=0, wr_len=0, wr_data=0, rd_bank=1, frame_done=0, frame_err=0, overflow=0. Write bank=0, FIFO empty, state IDLE.
- FSM states: IDLE, FILL, REQ, XFER, DRAIN.
- IDLE:
  - Pixels are discarded until din_vld&din_sop.
  - On sop: the sop word is written to the FIFO, addr pointer = base of write bank, word count = 1, frame_bad = 0, go to FILL.
- FILL (frame open):
  - Every din_vld word is written to the FIFO on the same edge.
  - When fifo_cnt ≥ BURST_LEN: go to REQ with wr_len=BURST_LEN.
- din_eop while the frame is open:
  - Frame closes, go to DRAIN.
  - frame_bad |= (word count ≠ FRAME_WORDS).
- din_sop while the frame is open (no eop yet):
  - Frame closes with frame_bad=1.
  - That sop word and all pixels up to the next accepted sop are discarded.
- In DRAIN and during any non-IDLE state after close:
  - A new sop is not accepted; that frame is skipped entirely.
  - The next sop is honoured only from IDLE.
- REQ: wr_req=1 with wr_addr/wr_len registered. On wr_ack, wr_req drops the same edge and the FSM goes to XFER.
- XFER:
  - Each wr_data_req pops one FIFO word; wr_data is registered and valid the next cycle.
  - A wr_data_req with the FIFO empty is a controller error; wr_data holds its last value.
  - On wr_done: addr += wr_len (ADDR_W wrap allowed, not checked). Return to FILL if the frame is open, else DRAIN.
- DRAIN:
  - fifo_cnt ≥ BURST_LEN → REQ, full burst.
  - 0 < fifo_cnt < BURST_LEN → REQ with wr_len=fifo_cnt (short tail burst).
  - fifo_cnt=0 → frame_done=1 for one cycle, frame_err=frame_bad, go to IDLE.
  - If frame_bad=0: rd_bank <= write bank and the write bank toggles on that same edge.
  - If frame_bad=1: both are unchanged; the next frame overwrites the same bank.
- FIFO writes continue in REQ/XFER while the frame is open. Simultaneous push and pop in one cycle leaves fifo_cnt unchanged.
- Overflow:
  - din_vld with the FIFO full drops the word and sets overflow (cleared only by rst).
  - Sets frame_bad.
  - The word count still increments, so length checking remains meaningful.
- wr_len is latched at REQ entry. Pixels arriving during REQ/XFER do not alter it.
- rst asserted mid-burst:
  - All state returns to reset values and the FIFO is flushed.
  - The controller must abandon the burst.

Decomposition:
- Shared package/header (param.v):
  - FRAME_WORDS derived from H_AP*V_AP.
  - BANK0_BASE/BANK1_BASE.
  - BURST_LEN.
  - FSM state encodings.
- One sub-module: sync_fifo.
  - Parameters: DATA_W, DEPTH.
  - Ports: wr_en, rd_en, registered rd_data, count, full, empty.
  - Same clk/rst.

Test Plan:
- Parameter override: BURST_LEN=8, FRAME_WORDS=20, FIFO_DEPTH=32.
- Clean frame of 20 words, controller acks in 2 cycles:
  - Expect bursts (addr 0, len 8), (8, 8), (16, 4).
  - Expect frame_done=1, frame_err=0, rd_bank 1→0.
  - Second clean frame writes from BANK1_BASE; rd_bank→1.
- Short frame (eop at word 15):
  - Expect bursts len 8 and 7.
  - Expect frame_done with frame_err=1, rd_bank unchanged; next frame reuses the same base.
- Controller stalls wr_ack for 40 cycles while 40 pixels stream in:
  - Expect overflow=1 after word 32 (sticky).
  - Expect frame_err=1; the popped data order matches the first 32 inputs.
- sop at word 10 of an open frame:
  - Expect the current frame closed bad with tail burst len 2 (after burst len 8).
  - The new frame is skipped; the following sop from IDLE is captured normally.
- Pixels before the first sop, plus rst asserted mid-XFER:
  - Pre-sop words never appear on wr_data.
  - After rst: all outputs are at reset values and the FIFO is empty.
- Default parameters, one full random 1280×720 frame:
  - Expect 3600 bursts of 256 ending at addr 921344, then one frame_done with frame_err=0.
